// File: rtl/mode_switch_controller_pkg.sv
// Shared constants and types for the mode-switch controller and its shadow stack.
package mode_switch_controller_pkg;

    // Flag-register update codes; 5..15 are owned by the controller
    localparam logic [3:0] UPD_NONE        = 4'd0;
    localparam logic [3:0] UPD_SHIFT       = 4'd1;
    localparam logic [3:0] UPD_ALU         = 4'd2;
    localparam logic [3:0] UPD_NZ          = 4'd3;
    localparam logic [3:0] UPD_V           = 4'd4;
    localparam logic [3:0] UPD_TOGGLE_MODE = 4'd5;
    localparam logic [3:0] UPD_BIOS_OFF    = 4'd7;

    // Bit positions inside the {N,Z,C,V,M} flag vector
    localparam int unsigned FLAG_N = 4;
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 1;
    localparam int unsigned FLAG_M = 0;

    // Bit positions inside the pending illegal-request acknowledge vector
    localparam int unsigned PEND_SWI  = 0;
    localparam int unsigned PEND_RET  = 1;
    localparam int unsigned PEND_BIOS = 2;

    typedef enum logic [2:0] {
        StIdle,
        StSwiSave,
        StSwiToggle,
        StRetRestore,
        StRetToggle,
        StBiosOff
    } state_e;

endpackage

// File: rtl/flag_shadow_stack.sv
// LIFO of saved {N,Z,C,V} nibbles; overflowing pushes and underflowing pops are dropped.
module flag_shadow_stack #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned DEPTH_W = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               clear,
    input  logic [3:0]         push_data,
    output logic [3:0]         top_data,
    output logic               full,
    output logic               empty,
    output logic [DEPTH_W-1:0] depth
);

    logic [3:0]         entries_q [DEPTH];
    logic [DEPTH_W-1:0] depth_q;

    assign full  = (depth_q == DEPTH_W'(DEPTH));
    assign empty = (depth_q == '0);
    assign depth = depth_q;

    // Storage and occupancy; clear has priority over push/pop
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            depth_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '0;
            end
        end else if (push && !full) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (depth_q == DEPTH_W'(i)) begin
                    entries_q[i] <= push_data;
                end
            end
            depth_q <= depth_q + 1'b1;
        end else if (pop && !empty) begin
            depth_q <= depth_q - 1'b1;
        end
    end

    // Top-of-stack read, zero when empty
    always_comb begin
        top_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (depth_q == DEPTH_W'(i + 1)) begin
                top_data = entries_q[i];
            end
        end
    end

endmodule

// File: rtl/mode_switch_controller.sv
// Arbitrates the flag register's update port between the datapath and SWI/return/BIOS events.
module mode_switch_controller
    import mode_switch_controller_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned DEPTH_W = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         dp_update_mode,
    input  logic               swi_req,
    input  logic               ret_req,
    input  logic               bios_exit_req,
    input  logic [4:0]         cur_flags,
    input  logic               is_bios,
    output logic [3:0]         spec_update_mode,
    output logic               restore_sel,
    output logic [3:0]         restore_flags,
    output logic               busy,
    output logic               swi_ack,
    output logic               ret_ack,
    output logic               bios_ack,
    output logic               fault,
    output logic [DEPTH_W-1:0] nest_depth
);

    state_e     state_q, state_d;
    // Illegal requests are answered one cycle later from IDLE without a state change
    logic [2:0] pend_q, pend_d;
    logic [3:0] restore_flags_q;

    logic       stk_push, stk_pop, stk_clear;
    logic [3:0] stk_top;
    logic       stk_full, stk_empty;

    flag_shadow_stack #(
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W)
    ) u_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (stk_push),
        .pop       (stk_pop),
        .clear     (stk_clear),
        .push_data (cur_flags[FLAG_N:FLAG_V]),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty),
        .depth     (nest_depth)
    );

    // State, pending-fault and held restore value registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= StIdle;
            pend_q          <= '0;
            restore_flags_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (state_q == StRetRestore) begin
                restore_flags_q <= stk_top;
            end
        end
    end

    // Next state: requests are sampled only in IDLE, and not while an illegal one is answered
    always_comb begin
        state_d = state_q;
        pend_d  = '0;
        unique case (state_q)
            StIdle: begin
                if (pend_q == '0) begin
                    if (bios_exit_req) begin
                        if (is_bios) state_d = StBiosOff;
                        else         pend_d[PEND_BIOS] = 1'b1;
                    end else if (ret_req) begin
                        if (stk_empty || cur_flags[FLAG_M]) pend_d[PEND_RET] = 1'b1;
                        else                                state_d = StRetRestore;
                    end else if (swi_req) begin
                        if (stk_full) pend_d[PEND_SWI] = 1'b1;
                        else          state_d = StSwiSave;
                    end
                end
            end
            StSwiSave:    state_d = StSwiToggle;
            StSwiToggle:  state_d = StIdle;
            StRetRestore: state_d = StRetToggle;
            StRetToggle:  state_d = StIdle;
            StBiosOff:    state_d = StIdle;
            default:      state_d = StIdle;
        endcase
    end

    // Outputs and stack controls per state; everything forced low during reset
    always_comb begin
        spec_update_mode = UPD_NONE;
        restore_sel      = 1'b0;
        busy             = 1'b0;
        swi_ack          = 1'b0;
        ret_ack          = 1'b0;
        bios_ack         = 1'b0;
        fault            = 1'b0;
        stk_push         = 1'b0;
        stk_pop          = 1'b0;
        stk_clear        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dp_update_mode <= UPD_V) spec_update_mode = dp_update_mode;
                else                         fault = 1'b1;
                if (pend_q != '0) fault = 1'b1;
                swi_ack  = pend_q[PEND_SWI];
                ret_ack  = pend_q[PEND_RET];
                bios_ack = pend_q[PEND_BIOS];
            end
            StSwiSave: begin
                busy     = 1'b1;
                stk_push = 1'b1;
            end
            StSwiToggle: begin
                busy             = 1'b1;
                spec_update_mode = UPD_TOGGLE_MODE;
                swi_ack          = 1'b1;
            end
            StRetRestore: begin
                busy             = 1'b1;
                stk_pop          = 1'b1;
                restore_sel      = 1'b1;
                spec_update_mode = UPD_ALU;
            end
            StRetToggle: begin
                busy             = 1'b1;
                spec_update_mode = UPD_TOGGLE_MODE;
                ret_ack          = 1'b1;
            end
            StBiosOff: begin
                busy             = 1'b1;
                spec_update_mode = UPD_BIOS_OFF;
                bios_ack         = 1'b1;
                stk_clear        = 1'b1;
            end
            default: ;
        endcase
        restore_flags = restore_sel ? stk_top : restore_flags_q;
        if (reset) begin
            spec_update_mode = UPD_NONE;
            restore_sel      = 1'b0;
            restore_flags    = '0;
            busy             = 1'b0;
            swi_ack          = 1'b0;
            ret_ack          = 1'b0;
            bios_ack         = 1'b0;
            fault            = 1'b0;
            stk_push         = 1'b0;
            stk_pop          = 1'b0;
        end
    end

endmodule

// File: doc/mode_switch_controller.md
Name: mode_switch_controller

Overview:
- Sequences every write to the special flag/mode register and shares its single update_mode port between the instruction datapath and mode-change events: software interrupt (SWI) entry, SWI return, and BIOS exit.
- On SWI entry it saves N,Z,C,V on a small shadow stack, then toggles the mode flag. On return it restores the saved flags and toggles the mode flag back.
- Sits in the control unit between the decoder and the flag register, and stalls the pipeline while it owns the register.

Parameters:
- DEPTH, 2, number of shadow-stack entries (maximum SWI nesting).
- DEPTH_W, 2, width of nest_depth; must be at least clog2(DEPTH+1).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- dp_update_mode  in  4  flag-update code requested by the decoder this cycle (0 none, 1 shifter, 2 ALU full, 3 N/Z only, 4 V only).
- swi_req  in  1  SWI entry request; level signal, held until swi_ack.
- ret_req  in  1  SWI return request; level signal, held until ret_ack.
- bios_exit_req  in  1  BIOS exit request; level signal, held until bios_ack.
- cur_flags  in  5  current {N,Z,C,V,M} read back from the flag register.
- is_bios  in  1  BIOS-active indication from the flag register.
- spec_update_mode  out  4  update code driven to the flag register.
- restore_sel  out  1  when 1, the flag register's ALU flag inputs are muxed to restore_flags.
- restore_flags  out  4  {N,Z,C,V} popped from the shadow stack.
- busy  out  1  pipeline stall; the controller owns the register.
- swi_ack, ret_ack, bios_ack  out  1 each  one-cycle completion pulses.
- fault  out  1  one-cycle illegal-request pulse.
- nest_depth  out  DEPTH_W  current shadow-stack occupancy.

Behaviour:
- Reset (synchronous, also mid-operation):
  - state to IDLE, stack cleared, nest_depth 0.
  - All outputs 0: spec_update_mode, restore_sel, restore_flags, busy, acks, fault.
  - Any in-flight sequence is abandoned and no ack is issued.
- States: IDLE, SWI_SAVE, SWI_TOGGLE, RET_RESTORE, RET_TOGGLE, BIOS_OFF.
- IDLE:
  - busy=0.
  - spec_update_mode = dp_update_mode if it is in 0..4. Codes 5..15 are reserved for this controller: drive 0 and pulse fault.
  - Event requests are sampled only in IDLE, with priority bios_exit_req > ret_req > swi_req.
  - In the acceptance cycle the datapath update still passes through, so the triggering instruction's flags are committed before the save.
- SWI entry (accepted at cycle t):
  - If nest_depth==DEPTH: fault=1 and swi_ack=1 in cycle t+1, no flag change, back to IDLE.
  - Otherwise, SWI_SAVE (t+1): push cur_flags[4:1], spec_update_mode=0, busy=1.
  - SWI_TOGGLE (t+2): spec_update_mode=5, swi_ack=1, busy=1.
  - IDLE at t+3, with the mode flag toggled as seen at t+3.
- Return (accepted at t):
  - If nest_depth==0 or cur_flags[0]==1: fault and ret_ack at t+1, no change.
  - Otherwise, RET_RESTORE (t+1): pop; restore_flags=popped entry, restore_sel=1, spec_update_mode=2.
  - RET_TOGGLE (t+2): spec_update_mode=5, ret_ack=1.
  - busy=1 in both cycles.
- BIOS exit (accepted at t):
  - If is_bios==0: fault and bios_ack at t+1.
  - Otherwise, BIOS_OFF (t+1): spec_update_mode=7, bios_ack=1, stack cleared, busy=1.
- While busy, dp_update_mode is ignored. Under busy stall the decoder must hold its request.
- restore_flags holds its last value when restore_sel=0.
- A request still asserted in the cycle after its ack is treated as a new request (requesters must drop on ack).

Decomposition:
- Shared package holds:
  - update-mode constants: UPD_NONE=0, UPD_SHIFT=1, UPD_ALU=2, UPD_NZ=3, UPD_V=4, UPD_TOGGLE_MODE=5, UPD_BIOS_OFF=7.
  - the FSM state enum.
  - the {N,Z,C,V,M} bit-index constants.
- Natural sub-module: flag_shadow_stack.
  - DEPTH-entry by 4-bit LIFO with push, pop, clear, full, empty, depth.
  - A push when full and a pop when empty are ignored.

Test Plan:
- Reset, then dp_update_mode=2 at cycle 3 → spec_update_mode=2 that cycle, busy=0. dp_update_mode=6 → spec_update_mode=0, fault pulses 1 cycle.
- cur_flags=5'b10101, swi_req at t → busy at t+1..t+2, spec_update_mode=0 then 5, swi_ack at t+2, nest_depth=1.
- Continuing, with M=0 and ret_req at t → at t+1 restore_sel=1, restore_flags=4'b1010, spec_update_mode=2; at t+2 mode 5 and ret_ack, nest_depth=0.
- Three nested SWIs with DEPTH=2 → third gives fault and swi_ack at t+1 with spec_update_mode=0. ret_req at depth 0 → fault and ret_ack.
- swi_req, ret_req and bios_exit_req together with is_bios=1 → BIOS_OFF wins: spec_update_mode=7, bios_ack. A second bios_exit_req with is_bios=0 → fault.
- reset asserted in SWI_SAVE → next cycle IDLE, nest_depth=0, no swi_ack, busy=0.
